// File: rtl/dmem_responder.sv
// Wait-stated single-port data memory slave: one request in flight,
// IDLE -> BUSY (WAIT cycles) -> RESP handshake with out-of-range error flag.
module dmem_responder #(
  parameter int NMEM = 128,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = (NMEM > 1) ? $clog2(NMEM) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_n_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_n_s;
  logic        wr_r;
  logic [6:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        accept_s;
  logic        access_s;
  logic        acc_wr_s;
  logic [6:0]  acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic        acc_ok_s;
  logic        mem_we_s;

  // Contents survive rst; only power-up clears them.
  logic [31:0] mem_r [DEPTH] = '{default: 32'h0000_0000};

  function automatic logic addr_in_range(input logic [6:0] a);
    return ({25'd0, a} < 32'(NMEM));
  endfunction

  // Next-state, wait counter and access strobe.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    accept_s  = 1'b0;
    access_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (WAIT == 0) begin
            access_s  = 1'b1;
            state_n_s = RESP;
          end else begin
            cnt_n_s   = WAIT_CNT;
            state_n_s = BUSY;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r <= 4'd1) begin
          access_s  = 1'b1;
          cnt_n_s   = 4'd0;
          state_n_s = RESP;
        end else begin
          cnt_n_s   = cnt_r - 4'd1;
          state_n_s = BUSY;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = RESP;
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = 4'd0;
      end
    endcase
  end

  // A zero-wait access happens on the accept edge, so it must use the live inputs.
  always_comb begin
    if (state_r == IDLE) begin
      acc_wr_s    = req_wr;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_wr_s    = wr_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
    acc_ok_s = addr_in_range(acc_addr_s);
    mem_we_s = access_s & acc_wr_s & acc_ok_s & ~rst;
  end

  // FSM state, latched request and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      addr_r  <= 7'd0;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      if (accept_s) begin
        wr_r    <= req_wr;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (access_s) begin
        rdata_r <= (!acc_wr_s && acc_ok_s) ? mem_r[acc_addr_s[AW-1:0]] : 32'h0000_0000;
        err_r   <= ~acc_ok_s;
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[acc_addr_s[AW-1:0]] <= acc_wdata_s;
    end
  end

  assign req_ready = (state_r == IDLE) & ~rst;
  assign rsp_valid = (state_r == RESP);
  assign busy      = (state_r != IDLE);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responders with different NMEM/WAIT settings share clk and rst.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [4];
  logic        req_wr    [4];
  logic [6:0]  req_addr  [4];
  logic [31:0] req_wdata [4];
  logic        req_ready [4];
  logic        rsp_valid [4];
  logic        rsp_ready [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];
  logic        busy      [4];

  int n_cmp = 0;
  int n_err = 0;

  // d0: NMEM=16 WAIT=2, d1: WAIT=0, d2: WAIT=4, d3: WAIT=3
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 4 : 3;
    localparam int N = (g == 0) ? 16 : 128;
    dmem_responder #(.NMEM(N), .WAIT(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_wr    (req_wr[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, drop req_valid after the accept edge, then count
  // cycles until rsp_valid. With noisy set, the other request fields churn.
  task automatic issue(input int d, input logic wr, input logic [6:0] a,
                       input logic [31:0] wd, input bit noisy, output int lat);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    tick();
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 64) begin
      if (noisy) begin
        req_addr[d]  = 7'(lat) + 7'd6;
        req_wdata[d] = $urandom;
        req_wr[d]    = ~wr;
      end
      tick();
      lat++;
    end
  endtask

  task automatic consume(input int d);
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'b0;
      req_addr[i]  = 7'd0;
      req_wdata[i] = 32'h0;
      rsp_ready[i] = 1'b0;
    end
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'h0);
    check("rst_err", 32'(rsp_err[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready[0]), 32'd1);

    // WAIT=2 write then read back
    issue(0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0, lat);
    check("w5_lat", 32'(lat), 32'd3);
    check("w5_rdata", rsp_rdata[0], 32'h0);
    check("w5_err", 32'(rsp_err[0]), 32'd0);
    consume(0);
    check("w5_done", 32'(rsp_valid[0]), 32'd0);
    issue(0, 1'b0, 7'd5, 32'h0, 1'b0, lat);
    check("r5_lat", 32'(lat), 32'd3);
    check("r5_rdata", rsp_rdata[0], 32'hDEADBEEF);
    check("r5_err", 32'(rsp_err[0]), 32'd0);
    consume(0);

    // NMEM=16 out-of-range accesses
    issue(0, 1'b1, 7'd20, 32'h12345678, 1'b0, lat);
    check("w20_err", 32'(rsp_err[0]), 32'd1);
    check("w20_rdata", rsp_rdata[0], 32'h0);
    consume(0);
    issue(0, 1'b0, 7'd20, 32'h0, 1'b0, lat);
    check("r20_err", 32'(rsp_err[0]), 32'd1);
    check("r20_rdata", rsp_rdata[0], 32'h0);
    consume(0);
    issue(0, 1'b0, 7'd4, 32'h0, 1'b0, lat);
    check("r4_err", 32'(rsp_err[0]), 32'd0);
    check("r4_rdata", rsp_rdata[0], 32'h0);
    consume(0);

    // Response held: back-pressure for 5 cycles with a second request pending
    issue(0, 1'b0, 7'd5, 32'h0, 1'b0, lat);
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 7'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid[0]), 32'd1);
      check("hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("hold_err", 32'(rsp_err[0]), 32'd0);
      check("hold_ready", 32'(req_ready[0]), 32'd0);
      check("hold_busy", 32'(busy[0]), 32'd1);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("rel_idle_valid", 32'(rsp_valid[0]), 32'd0);
    check("rel_idle_ready", 32'(req_ready[0]), 32'd1);
    check("rel_idle_busy", 32'(busy[0]), 32'd0);
    tick();
    req_valid[0] = 1'b0;
    check("second_acc_busy", 32'(busy[0]), 32'd1);
    check("second_acc_ready", 32'(req_ready[0]), 32'd0);
    lat = 1;
    while (rsp_valid[0] !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("second_lat", 32'(lat), 32'd3);
    check("second_rdata", rsp_rdata[0], 32'h0);
    consume(0);

    // WAIT=0 back-to-back with rsp_ready tied high
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b0;
    req_addr[1]  = 7'd0;
    tick();
    check("w0_r0_valid", 32'(rsp_valid[1]), 32'd1);
    check("w0_r0_rdata", rsp_rdata[1], 32'h0);
    check("w0_r0_ready", 32'(req_ready[1]), 32'd0);
    req_wr[1]    = 1'b1;
    req_addr[1]  = 7'd3;
    req_wdata[1] = 32'h0BADF00D;
    tick();
    check("w0_gap_valid", 32'(rsp_valid[1]), 32'd0);
    check("w0_gap_ready", 32'(req_ready[1]), 32'd1);
    tick();
    check("w0_w3_valid", 32'(rsp_valid[1]), 32'd1);
    check("w0_w3_rdata", rsp_rdata[1], 32'h0);
    req_wr[1] = 1'b0;
    tick();
    check("w0_gap2_valid", 32'(rsp_valid[1]), 32'd0);
    tick();
    req_valid[1] = 1'b0;
    check("w0_r3_valid", 32'(rsp_valid[1]), 32'd1);
    check("w0_r3_rdata", rsp_rdata[1], 32'h0BADF00D);
    tick();
    rsp_ready[1] = 1'b0;
    check("w0_end_busy", 32'(busy[1]), 32'd0);

    // WAIT=4: reset abandons a pending write, memory survives reset
    issue(2, 1'b1, 7'd10, 32'h11111111, 1'b0, lat);
    check("w10_lat", 32'(lat), 32'd5);
    consume(2);
    issue(2, 1'b0, 7'd10, 32'h0, 1'b0, lat);
    check("r10_rdata", rsp_rdata[2], 32'h11111111);
    consume(2);
    req_valid[2] = 1'b1;
    req_wr[2]    = 1'b1;
    req_addr[2]  = 7'd9;
    req_wdata[2] = 32'hA5A5A5A5;
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy[2]), 32'd0);
    check("abort_ready", 32'(req_ready[2]), 32'd0);
    check("abort_valid", 32'(rsp_valid[2]), 32'd0);
    check("abort_rdata", rsp_rdata[2], 32'h0);
    check("abort_err", 32'(rsp_err[2]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    issue(2, 1'b0, 7'd9, 32'h0, 1'b0, lat);
    check("r9_lat", 32'(lat), 32'd5);
    check("r9_rdata", rsp_rdata[2], 32'h0);
    consume(2);
    issue(2, 1'b0, 7'd10, 32'h0, 1'b0, lat);
    check("r10_after_rst", rsp_rdata[2], 32'h11111111);
    consume(2);

    // WAIT=3: request fields churn during BUSY
    issue(3, 1'b1, 7'd7, 32'hCAFEF00D, 1'b1, lat);
    check("noisy_w_lat", 32'(lat), 32'd4);
    check("noisy_w_rdata", rsp_rdata[3], 32'h0);
    check("noisy_w_err", 32'(rsp_err[3]), 32'd0);
    consume(3);
    issue(3, 1'b0, 7'd7, 32'h0, 1'b0, lat);
    check("r7_rdata", rsp_rdata[3], 32'hCAFEF00D);
    consume(3);
    issue(3, 1'b0, 7'd8, 32'h0, 1'b1, lat);
    check("noisy_r8_rdata", rsp_rdata[3], 32'h0);
    consume(3);
    issue(3, 1'b0, 7'd9, 32'h0, 1'b0, lat);
    check("r9_untouched", rsp_rdata[3], 32'h0);
    consume(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
